// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS control tokens, aligner state type and 10b->8b decode helpers
package tmds_pkg;

  localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } align_state_t;

  function automatic logic is_ctrl_token(input logic [9:0] q);
    return (q == CTRL_TOK_00) || (q == CTRL_TOK_01) ||
           (q == CTRL_TOK_10) || (q == CTRL_TOK_11);
  endfunction

  function automatic logic [1:0] ctrl_value(input logic [9:0] q);
    logic [1:0] v;
    v = 2'b00;
    case (q)
      CTRL_TOK_01: v = 2'b01;
      CTRL_TOK_10: v = 2'b10;
      CTRL_TOK_11: v = 2'b11;
      default:     v = 2'b00;
    endcase
    return v;
  endfunction

  // q[9] undoes the transmitter's inversion, q[8] selects XOR vs XNOR chaining
  function automatic logic [7:0] tmds_decode(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] o;
    d = q[9] ? ~q[7:0] : q[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return o;
  endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// rtl/tmds_word_aligner.sv - bit-slip word aligner with lock FSM; TMDS_DEC_STATS_EN adds relock counter
module tmds_word_aligner #(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [9:0]  sym,
  output logic [9:0]  aligned_word,
  output logic        locked,
  output logic [3:0]  offset
`ifdef TMDS_DEC_STATS_EN
  ,
  output logic [15:0] relock_cnt
`endif
);
  import tmds_pkg::*;

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int SRCH_W = $clog2(SEARCH_TIMEOUT + 1);
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);

  logic [9:0]        s1, s2;
  logic [19:0]       window;
  logic [9:0]        w;
  logic              tok;
  align_state_t      state, state_next;
  logic [RUN_W-1:0]  run, run_next;
  logic [SRCH_W-1:0] search_tmr, search_next;
  logic [LOSS_W-1:0] loss_tmr, loss_next;
  logic [3:0]        offset_next;

  // older word in the low half: bit 0 of s2 is the earliest received bit
  assign window = {s1, s2};
  assign w      = window[{1'b0, offset} +: 10];
  assign tok    = is_ctrl_token(aligned_word);
  assign locked = (state == ST_LOCKED);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1           <= '0;
      s2           <= '0;
      aligned_word <= '0;
    end else begin
      s1           <= sym;
      s2           <= s1;
      aligned_word <= w;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_SEARCH;
      run        <= '0;
      search_tmr <= '0;
      loss_tmr   <= '0;
      offset     <= '0;
    end else begin
      state      <= state_next;
      run        <= run_next;
      search_tmr <= search_next;
      loss_tmr   <= loss_next;
      offset     <= offset_next;
    end
  end

  always_comb begin
    state_next  = state;
    run_next    = run;
    search_next = search_tmr;
    loss_next   = loss_tmr;
    offset_next = offset;
    case (state)
      ST_SEARCH: begin
        loss_next   = '0;
        run_next    = tok ? run + 1'b1 : '0;
        search_next = search_tmr + 1'b1;
        // a completed run takes priority over a simultaneous slip
        if (tok && (run == RUN_W'(LOCK_COUNT - 1))) begin
          state_next  = ST_LOCKED;
          run_next    = '0;
          search_next = '0;
        end else if (search_tmr == SRCH_W'(SEARCH_TIMEOUT - 1)) begin
          offset_next = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
          run_next    = '0;
          search_next = '0;
        end
      end
      ST_LOCKED: begin
        run_next    = '0;
        search_next = '0;
        loss_next   = tok ? '0 : loss_tmr + 1'b1;
        if (!tok && (loss_tmr == LOSS_W'(LOSS_TIMEOUT - 1))) begin
          state_next = ST_SEARCH;
          loss_next  = '0;
        end
      end
      default: state_next = ST_SEARCH;
    endcase
  end

`ifdef TMDS_DEC_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      relock_cnt <= '0;
    end else if ((state == ST_LOCKED) && (state_next == ST_SEARCH) &&
                 (relock_cnt != 16'hFFFF)) begin
      relock_cnt <= relock_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - one TMDS receive channel: alignment, decode, registered outputs; TMDS_DEC_STATS_EN adds o_relock_cnt
module tmds_channel_decoder #(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [9:0]  i_sym,
  output logic [7:0]  o_data,
  output logic [1:0]  o_ctrl,
  output logic        o_de,
  output logic        o_locked,
  output logic [3:0]  o_offset
`ifdef TMDS_DEC_STATS_EN
  ,
  output logic [15:0] o_relock_cnt
`endif
);
  import tmds_pkg::*;

  logic [9:0] aligned_word;
  logic       locked;

  tmds_word_aligner #(
    .LOCK_COUNT     (LOCK_COUNT),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .LOSS_TIMEOUT   (LOSS_TIMEOUT)
  ) u_aligner (
    .clk          (clk),
    .rstn         (rstn),
    .sym          (i_sym),
    .aligned_word (aligned_word),
    .locked       (locked),
    .offset       (o_offset)
`ifdef TMDS_DEC_STATS_EN
    ,
    .relock_cnt   (o_relock_cnt)
`endif
  );

  assign o_locked = locked;

  // gating uses the lock state before this edge, so the run-completing word stays masked
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_data <= '0;
      o_ctrl <= '0;
      o_de   <= 1'b0;
    end else if (!locked) begin
      o_data <= '0;
      o_ctrl <= '0;
      o_de   <= 1'b0;
    end else if (is_ctrl_token(aligned_word)) begin
      o_data <= '0;
      o_ctrl <= ctrl_value(aligned_word);
      o_de   <= 1'b0;
    end else begin
      o_data <= tmds_decode(aligned_word);
      o_de   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - directed scoreboard bench for tmds_channel_decoder
module tb_tmds_channel_decoder;

  localparam int LOCK_COUNT     = 8;
  localparam int SEARCH_TIMEOUT = 2048;
  localparam int LOSS_TIMEOUT   = 4096;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  i_sym;
  logic [7:0]  o_data;
  logic [1:0]  o_ctrl;
  logic        o_de;
  logic        o_locked;
  logic [3:0]  o_offset;
`ifdef TMDS_DEC_STATS_EN
  logic [15:0] o_relock_cnt;
`endif

  tmds_channel_decoder #(
    .LOCK_COUNT     (LOCK_COUNT),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .LOSS_TIMEOUT   (LOSS_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .i_sym    (i_sym),
    .o_data   (o_data),
    .o_ctrl   (o_ctrl),
    .o_de     (o_de),
    .o_locked (o_locked),
    .o_offset (o_offset)
`ifdef TMDS_DEC_STATS_EN
    ,
    .o_relock_cnt (o_relock_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         cycle = 0;
  int         r;
  logic       got;
  logic       noisy;
  logic [1:0] model_ctrl;
  logic [3:0] prev_off;
  logic [9:0] tk;
  logic [9:0] rot;
  logic [9:0] x;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_tok(input logic [9:0] q);
    return (q == T00) || (q == T01) || (q == T10) || (q == T11);
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] q);
    logic [7:0] d;
    logic [7:0] o;
    d = q[7:0] ^ {8{q[9]}};
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = d[i] ^ d[i-1] ^ ~q[8];
    return o;
  endfunction

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cycle++;
    if (sb.size() > 0 && sb[0].due == cycle) begin
      e = sb.pop_front();
      check("sb_de",   16'(o_de),   16'(e.de));
      check("sb_data", 16'(o_data), 16'(e.data));
      check("sb_ctrl", 16'(o_ctrl), 16'(e.ctrl));
    end
  endtask

  // word driven now is sampled next edge and reaches the outputs three edges later
  task automatic send(input logic [9:0] s);
    exp_t e;
    e.due = cycle + 4;
    i_sym = s;
    if (is_tok(s)) begin
      e.de = 1'b0;
      e.data = 8'h00;
      case (s)
        T01:     e.ctrl = 2'b01;
        T10:     e.ctrl = 2'b10;
        T11:     e.ctrl = 2'b11;
        default: e.ctrl = 2'b00;
      endcase
      model_ctrl = e.ctrl;
    end else begin
      e.de = 1'b1;
      e.data = ref_decode(s);
      e.ctrl = model_ctrl;
    end
    sb.push_back(e);
    step();
  endtask

  initial begin
    rstn = 1'b0;
    i_sym = '0;
    for (int i = 0; i < 6; i++) begin
      i_sym = 10'($urandom);
      step();
    end
    check("rst_data",   16'(o_data),   16'h0);
    check("rst_ctrl",   16'(o_ctrl),   16'h0);
    check("rst_de",     16'(o_de),     16'h0);
    check("rst_locked", 16'(o_locked), 16'h0);
    check("rst_offset", 16'(o_offset), 16'h0);

    // aligned token stream straight out of reset
    rstn = 1'b1;
    i_sym = T00;
    r = cycle;
    got = 1'b0;
    noisy = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      if (o_locked) got = 1'b1;
      else if (o_de !== 1'b0 || o_data !== 8'h00) noisy = 1'b1;
    end
    check("lock_seen",    16'(got),        16'h1);
    check("lock_latency", 16'(cycle - r),  16'(LOCK_COUNT + 3));
    check("pre_lock_out", 16'(noisy),      16'h0);
    check("lock_offset",  16'(o_offset),   16'h0);
    step();
    check("lock_ctrl",    16'(o_ctrl),     16'h0);
    check("lock_de",      16'(o_de),       16'h0);

    model_ctrl = 2'b00;
    send(T10);
    send(10'h100);
    send(10'h200);
    for (int i = 0; i < 6; i++) begin
      x = 10'($urandom);
      while (is_tok(x)) x = 10'($urandom);
      send(x);
    end
    send(T11);
    send(10'h155);
    send(T01);
    send(10'h0F0);
    i_sym = 10'h200;
    for (int i = 0; i < 10 && sb.size() > 0; i++) step();
    check("sb_drained", 16'(sb.size()), 16'h0);

    check("pre_arst_locked", 16'(o_locked), 16'h1);
    check("pre_arst_ctrl",   16'(o_ctrl),   16'h1);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_locked", 16'(o_locked), 16'h0);
    check("arst_de",     16'(o_de),     16'h0);
    check("arst_data",   16'(o_data),   16'h0);
    check("arst_ctrl",   16'(o_ctrl),   16'h0);
    check("arst_offset", 16'(o_offset), 16'h0);
    step();
    step();

    // token stream whose symbol boundary sits 3 bits into each word
    tk = T11;
    rot = {tk[6:0], tk[9:7]};
    rstn = 1'b1;
    i_sym = rot;
    r = cycle;
    prev_off = 4'd0;
    for (int k = 1; k <= 3; k++) begin
      got = 1'b0;
      for (int i = 0; i < SEARCH_TIMEOUT + 50 && !got; i++) begin
        step();
        if (o_offset !== prev_off) got = 1'b1;
      end
      check("slip_seen",     16'(got),       16'h1);
      check("slip_offset",   16'(o_offset),  16'(k));
      check("slip_interval", 16'(cycle - r), 16'(k * SEARCH_TIMEOUT));
      check("slip_unlocked", 16'(o_locked),  16'h0);
      prev_off = o_offset;
    end
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      if (o_locked) got = 1'b1;
    end
    check("relock_seen",    16'(got),       16'h1);
    check("relock_latency", 16'(cycle - r), 16'(3 * SEARCH_TIMEOUT + LOCK_COUNT + 1));
    check("relock_offset",  16'(o_offset),  16'h3);
    step();
    check("relock_ctrl",    16'(o_ctrl),    16'h3);
    check("relock_de",      16'(o_de),      16'h0);

    // at offset 3 the first word straddling old and new input is already a non-token
    i_sym = 10'h100;
    r = cycle;
    got = 1'b0;
    for (int i = 0; i < LOSS_TIMEOUT + 100 && !got; i++) begin
      step();
      if (!o_locked) got = 1'b1;
    end
    check("loss_seen",    16'(got),       16'h1);
    check("loss_latency", 16'(cycle - r), 16'(LOSS_TIMEOUT + 2));
    step();
    check("loss_de",      16'(o_de),      16'h0);
    check("loss_data",    16'(o_data),    16'h0);
    check("loss_locked",  16'(o_locked),  16'h0);
    check("loss_offset",  16'(o_offset),  16'h3);
`ifdef TMDS_DEC_STATS_EN
    check("relock_cnt",   o_relock_cnt,   16'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
